tdm_demux: RTL and testbench

//   Receive end of the 2:1 select-line mux path. A single time-multiplexed bit

---
 rtl/tdm_demux_pkg.sv | 24 ++
 rtl/tdm_demux_if.sv | 38 +++
 rtl/tdm_demux_chan.sv | 122 ++++++++++++
 rtl/tdm_demux.sv | 54 +++++
 tb/tb_tdm_demux.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types and helpers for the TDM receive demux
//
// Purpose: channel and holding-register enums plus the counter width helper
//          used by tdm_demux and tdm_demux_chan.
// Ports:   none (package).

package tdm_demux_pkg;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_e;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_e;

    // Bits needed for a counter running 0..width-1 (width >= 2).
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial link input and per-channel word outputs
//
// Purpose: bundles the serial input side (din/din_valid/sel/sync/ovf_clr)
//          and the two per-channel valid/ready word streams.
// Ports:   master - the link/consumer side (drives din, din_valid, sel, sync,
//                   ovf_clr, a_ready, b_ready)
//          slave  - the demux (drives a_data/a_valid/a_ovf, b_data/b_valid/b_ovf)

interface tdm_demux_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             din_valid;
    logic             sel;
    logic             sync;
    logic             ovf_clr;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic             a_ovf;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic             b_ovf;

    modport master (
        output din, din_valid, sel, sync, ovf_clr, a_ready, b_ready,
        input  a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
    );

    modport slave (
        input  din, din_valid, sel, sync, ovf_clr, a_ready, b_ready,
        output a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
    );

endinterface

// File: rtl/tdm_demux_chan.sv
// rtl/tdm_demux_chan.sv - one channel: bit assembler, holding reg, overflow flag
//
// Purpose: shifts qualified bits in MSB first, hands each completed word to a
//          1-entry holding register presented as a valid/ready output, and
//          flags words dropped because the holding register was still full.
// Ports:   clk, rst           - clock, synchronous active-high reset
//          bit_en, din        - take din as the next bit of this channel
//          sync               - restart word alignment (counter to 0)
//          ovf_clr            - clear the sticky overflow flag
//          ready              - consumer accepts data when valid & ready
//          data, valid, ovf   - held word, word present, sticky drop flag

module tdm_demux_chan
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             din,
    input  logic             sync,
    input  logic             ovf_clr,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ovf
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 bits of history are ever needed; the last bit comes from din.
    logic [WIDTH-2:0] shreg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-2:0] shreg_eff;
    logic [CW-1:0]    cnt_eff;
    logic [WIDTH-1:0] word;
    logic             done;

    hold_e            state;
    hold_e            state_nxt;
    logic             load;
    logic             ovf_set;

    // sync discards the partial word before the current bit is applied, so a
    // bit arriving with sync becomes bit 0 of the new word.
    always_comb begin
        shreg_eff = sync ? '0 : shreg;
        cnt_eff   = sync ? '0 : cnt;
        word      = {shreg_eff, din};
        done      = bit_en && (cnt_eff == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bit_en) begin
            shreg <= word[WIDTH-2:0];
            cnt   <= done ? '0 : cnt_eff + CW'(1);
        end else if (sync) begin
            shreg <= '0;
            cnt   <= '0;
        end
    end

    // Holding register: a completion in the same cycle as an accept replaces
    // the word without a bubble; without an accept the new word is dropped.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            HOLD_EMPTY: begin
                if (done) begin
                    state_nxt = HOLD_FULL;
                    load      = 1'b1;
                end
            end
            HOLD_FULL: begin
                if (done) begin
                    if (ready) begin
                        load = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (ready) begin
                    state_nxt = HOLD_EMPTY;
                end
            end
            default: state_nxt = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD_EMPTY;
            data  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                data <= word;
            end
        end
    end

    // A drop in the same cycle as ovf_clr leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign valid = (state == HOLD_FULL);

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - 2:1 TDM receive demux, serial bits to per-channel words
//
// Purpose: decodes sel to steer each qualified serial bit to channel A or B
//          and assembles WIDTH-bit words (MSB first) per channel.
// Ports:   clk  - clock, all logic on the rising edge
//          rst  - synchronous active-high reset
//          bus  - tdm_demux_if slave: serial input, sync/ovf_clr controls,
//                 channel A and B valid/ready word outputs with overflow flags

module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux_if.slave   bus
);

    logic bit_en_a;
    logic bit_en_b;

    always_comb begin
        bit_en_a = bus.din_valid && (ch_e'(bus.sel) == CH_A);
        bit_en_b = bus.din_valid && (ch_e'(bus.sel) == CH_B);
    end

    tdm_demux_chan #(.WIDTH(WIDTH)) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en_a),
        .din     (bus.din),
        .sync    (bus.sync),
        .ovf_clr (bus.ovf_clr),
        .ready   (bus.a_ready),
        .data    (bus.a_data),
        .valid   (bus.a_valid),
        .ovf     (bus.a_ovf)
    );

    tdm_demux_chan #(.WIDTH(WIDTH)) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en_b),
        .din     (bus.din),
        .sync    (bus.sync),
        .ovf_clr (bus.ovf_clr),
        .ready   (bus.b_ready),
        .data    (bus.b_data),
        .valid   (bus.b_valid),
        .ovf     (bus.b_ovf)
    );

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux

module tb_tdm_demux;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    tdm_demux_if #(.WIDTH(W)) bus ();

    tdm_demux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, the partial word as an integer, the number
    // of bits collected, and a one-slot mailbox with a sticky drop flag.
    int         m_part [2];
    int         m_cnt  [2];
    bit         m_full [2];
    logic [W-1:0] m_data [2];
    bit         m_ovf  [2];

    task automatic model_step();
        bit           rdy;
        bit           en;
        bit           done;
        bit           drop;
        logic [W-1:0] w;
        for (int k = 0; k < 2; k++) begin
            rdy = (k == 0) ? bus.a_ready : bus.b_ready;
            en  = bus.din_valid && (bus.sel == (k == 1));
            if (rst) begin
                m_part[k] = 0; m_cnt[k] = 0; m_full[k] = 0;
                m_data[k] = '0; m_ovf[k] = 0;
            end else begin
                done = 0; drop = 0; w = '0;
                if (bus.sync) begin
                    m_part[k] = 0; m_cnt[k] = 0;
                end
                if (en) begin
                    m_part[k] = (m_part[k] * 2 + int'(bus.din)) % (1 << W);
                    m_cnt[k]  = m_cnt[k] + 1;
                    if (m_cnt[k] == W) begin
                        done = 1; w = m_part[k][W-1:0];
                        m_cnt[k] = 0; m_part[k] = 0;
                    end
                end
                if (m_full[k] && rdy) m_full[k] = 0;
                if (done) begin
                    if (!m_full[k]) begin
                        m_full[k] = 1; m_data[k] = w;
                    end else begin
                        drop = 1;
                    end
                end
                if (drop) m_ovf[k] = 1;
                else if (bus.ovf_clr) m_ovf[k] = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din = 0; bus.din_valid = 0; bus.sel = 0; bus.sync = 0; bus.ovf_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic send_bit(input bit ch, input bit b, input bit s);
        bus.din_valid = 1; bus.sel = ch; bus.din = b; bus.sync = s;
        tick();
        idle_inputs();
    endtask

    // Sends a word MSB first with no idle cycles; counts valid-high samples on
    // that channel after bits 1..W-1 (before the word can have completed).
    task automatic send_word(input bit ch, input logic [W-1:0] w, output int early);
        early = 0;
        for (int i = W - 1; i >= 0; i--) begin
            bus.din_valid = 1; bus.sel = ch; bus.din = w[i]; bus.sync = 0;
            tick();
            if (i != 0 && ((ch == 0) ? bus.a_valid : bus.b_valid)) early++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        bus.a_ready = 1; bus.b_ready = 1;
        do_reset();
        checks++;
        if ({bus.a_valid, bus.b_valid, bus.a_ovf, bus.b_ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.a_valid, bus.b_valid, bus.a_ovf, bus.b_ovf});
        end
        checks++;
        if ({bus.a_data, bus.b_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h expected 00/00", bus.a_data, bus.b_data);
        end
    endtask

    task automatic test_single_word();
        int early;
        do_reset();
        send_word(0, 8'hA5, early);
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL t1_early_valid: got %0d expected 0", early);
        end
        checks++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 8'hA5) begin
            errors++;
            $display("FAIL t1_word: got valid=%b data=%h expected 1/a5", bus.a_valid, bus.a_data);
        end
        checks++;
        if (bus.b_valid !== 1'b0) begin
            errors++; $display("FAIL t1_b_valid: got %b expected 0", bus.b_valid);
        end
        tick();
        checks++;
        if (bus.a_valid !== 1'b0) begin
            errors++; $display("FAIL t1_one_cycle: got %b expected 0", bus.a_valid);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        for (int i = 0; i < 2 * W; i++) begin
            bus.din_valid = 1; bus.sel = i[0]; bus.din = ~i[0]; bus.sync = 0;
            tick();
            if (i == 2 * W - 2) begin
                checks++;
                if (bus.a_valid !== 1'b1 || bus.a_data !== 8'hFF || bus.b_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL t2_a_word: got a_valid=%b a_data=%h b_valid=%b expected 1/ff/0",
                             bus.a_valid, bus.a_data, bus.b_valid);
                end
            end
        end
        idle_inputs();
        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== 8'h00 || bus.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL t2_b_word: got b_valid=%b b_data=%h a_valid=%b expected 1/00/0",
                     bus.b_valid, bus.b_data, bus.a_valid);
        end
    endtask

    task automatic test_overflow();
        int early;
        do_reset();
        bus.a_ready = 0;
        send_word(0, 8'h11, early);
        checks++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h11 || bus.a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL t3_first: got valid=%b data=%h ovf=%b expected 1/11/0",
                     bus.a_valid, bus.a_data, bus.a_ovf);
        end
        send_word(0, 8'h22, early);
        checks++;
        if (bus.a_data !== 8'h11 || bus.a_ovf !== 1'b1 || bus.a_valid !== 1'b1) begin
            errors++;
            $display("FAIL t3_drop: got valid=%b data=%h ovf=%b expected 1/11/1",
                     bus.a_valid, bus.a_data, bus.a_ovf);
        end
        bus.ovf_clr = 1;
        tick();
        bus.ovf_clr = 0;
        checks++;
        if (bus.a_ovf !== 1'b0 || bus.a_data !== 8'h11) begin
            errors++;
            $display("FAIL t3_clear: got ovf=%b data=%h expected 0/11", bus.a_ovf, bus.a_data);
        end
        // Drop coinciding with ovf_clr: the set must win.
        for (int i = W - 1; i >= 0; i--) begin
            bus.din_valid = 1; bus.sel = 0; bus.din = i[0]; bus.ovf_clr = (i == 0);
            tick();
        end
        idle_inputs();
        checks++;
        if (bus.a_ovf !== 1'b1 || bus.a_data !== 8'h11) begin
            errors++;
            $display("FAIL t3_set_wins: got ovf=%b data=%h expected 1/11", bus.a_ovf, bus.a_data);
        end
        bus.a_ready = 1;
        tick();
        checks++;
        if (bus.a_valid !== 1'b0) begin
            errors++; $display("FAIL t3_drain: got %b expected 0", bus.a_valid);
        end
    endtask

    task automatic test_back_to_back();
        int early;
        do_reset();
        bus.a_ready = 1;
        send_word(0, 8'h3C, early);
        checks++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h3C) begin
            errors++;
            $display("FAIL t4_first: got valid=%b data=%h expected 1/3c", bus.a_valid, bus.a_data);
        end
        send_word(0, 8'hC3, early);
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL t4_single_pulse: got %0d extra valid cycles expected 0", early);
        end
        checks++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== 8'hC3 || bus.a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL t4_second: got valid=%b data=%h ovf=%b expected 1/c3/0",
                     bus.a_valid, bus.a_data, bus.a_ovf);
        end
    endtask

    task automatic test_mid_word_reset();
        int early;
        do_reset();
        send_bit(0, 1, 0); send_bit(0, 1, 0); send_bit(0, 0, 0);
        do_reset();
        send_word(0, 8'h5A, early);
        checks++;
        if (early !== 0 || bus.a_valid !== 1'b1 || bus.a_data !== 8'h5A) begin
            errors++;
            $display("FAIL t5_reset_word: got early=%0d valid=%b data=%h expected 0/1/5a",
                     early, bus.a_valid, bus.a_data);
        end
    endtask

    task automatic test_sync();
        logic [W-1:0] w;
        int           early;
        do_reset();
        send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0);
        send_bit(0, 1, 0); send_bit(0, 0, 0);
        w = 8'h81;
        early = 0;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(0, w[i], (i == W - 1));
            if (i != 0 && bus.a_valid) early++;
        end
        checks++;
        if (early !== 0 || bus.a_valid !== 1'b1 || bus.a_data !== 8'h81) begin
            errors++;
            $display("FAIL t6_sync_word: got early=%0d valid=%b data=%h expected 0/1/81",
                     early, bus.a_valid, bus.a_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.din_valid = ($urandom_range(0, 3) != 0);
            bus.sel       = $urandom_range(0, 1);
            bus.din       = $urandom_range(0, 1);
            bus.sync      = ($urandom_range(0, 29) == 0);
            bus.ovf_clr   = ($urandom_range(0, 15) == 0);
            bus.a_ready   = ($urandom_range(0, 2) == 0);
            bus.b_ready   = ($urandom_range(0, 1) == 0);
            tick();
            checks++;
            if ({bus.a_valid, bus.a_ovf, bus.b_valid, bus.b_ovf} !==
                {m_full[0], m_ovf[0], m_full[1], m_ovf[1]}) begin
                errors++;
                $display("FAIL rand_flags cycle %0d: got %b expected %b", n,
                         {bus.a_valid, bus.a_ovf, bus.b_valid, bus.b_ovf},
                         {m_full[0], m_ovf[0], m_full[1], m_ovf[1]});
            end
            if (m_full[0]) begin
                checks++;
                if (bus.a_data !== m_data[0]) begin
                    errors++;
                    $display("FAIL rand_a_data cycle %0d: got %h expected %h", n, bus.a_data, m_data[0]);
                end
            end
            if (m_full[1]) begin
                checks++;
                if (bus.b_data !== m_data[1]) begin
                    errors++;
                    $display("FAIL rand_b_data cycle %0d: got %h expected %h", n, bus.b_data, m_data[1]);
                end
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.a_ready = 1;
        bus.b_ready = 1;
        test_reset();
        test_single_word();
        test_interleave();
        test_overflow();
        test_back_to_back();
        test_mid_word_reset();
        test_sync();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
